alu_4bit: RTL and testbench
===========================

ALU_4BIT -- requirements
Module: alu_4bit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 4-bit operands and a 3-bit opcode.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset:
  clk    input  1  rising-edge clock for all state.
  reset  input  1  synchronous, active-high reset.
REQ-003 The operand, opcode and result ports SHALL be as follows:
  x0     input  1  operand A bit 3 (MSB).
  x1     input  1  operand A bit 2.
  x2     input  1  operand A bit 1.
  x3     input  1  operand A bit 0 (LSB).
  y0     input  1  operand B bit 3 (MSB).
  y1     input  1  operand B bit 2.
  y2     input  1  operand B bit 1.
  y3     input  1  operand B bit 0 (LSB).
  op0    input  1  opcode bit 2 (MSB).
  op1    input  1  opcode bit 1.
  op2    input  1  opcode bit 0 (LSB).
  out0   output 1  result bit 3 (MSB), registered.
  out1   output 1  result bit 2, registered.
  out2   output 1  result bit 1, registered.
  out3   output 1  result bit 0 (LSB), registered.
  carry  output 1  carry/borrow flag, registered.

Function
In this section A = {x0,x1,x2,x3}, B = {y0,y1,y2,y3}, OP = {op0,op1,op2}, R = {out0,out1,out2,out3}; all values are unsigned and taken mod 16.
REQ-004 On every rising clk edge with reset low, R and carry SHALL load the result of OP applied to the A/B/OP values sampled at that edge; latency is 1 cycle, throughput is 1 result per cycle, and there is no handshake.
REQ-005 OP=000 (AND) SHALL give R = A & B and carry = 0.
REQ-006 OP=001 (NOT) SHALL give R = ~A and carry = 0; B is ignored.
REQ-007 OP=010 (OR) SHALL give R = A | B and carry = 0.
REQ-008 OP=011 (XOR) SHALL give R = A ^ B and carry = 0.
REQ-009 OP=100 (SHIFT LEFT) SHALL give R = {A[2:0],0} and carry = A[3] (the bit shifted out); B is ignored.
REQ-010 OP=101 (ADD) SHALL give {carry,R} = A + B as a 5-bit sum.
REQ-011 OP=110 (SUB) SHALL give R = (A - B) mod 16 and carry = 1 exactly when A < B (borrow).
REQ-012 OP=111 (TWOS COMPLEMENT) SHALL give R = (~A + 1) mod 16 and carry = 1 exactly when A = 0000; B is ignored.
REQ-013 Outputs SHALL hold their value between clock edges; input changes between edges SHALL have no effect on the outputs.

Reset
REQ-014 When reset is high at a rising clk edge, R SHALL become 0000 and carry SHALL become 0, regardless of A, B and OP.
REQ-015 Reset SHALL take priority over computation, and the first result SHALL appear on the first edge with reset low.

Configuration
REQ-016 With macro ALU_TWOS_COMP_EN defined, OP=111 SHALL behave as specified in REQ-012.
REQ-017 Without ALU_TWOS_COMP_EN, OP=111 SHALL load R = 0000 and carry = 0, and all other opcodes SHALL be unchanged.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
  - Reset high for one edge with A=1111, B=1111, OP=101 -> R=0000, carry=0.
  - A=1011, B=0010, then OP=000/001/010/011 -> R=0010/0100/1011/1001, carry=0 each; each result visible 1 cycle after its opcode.
  - A=1011, B=0010, OP=100 -> R=0110, carry=1; then OP=101 -> R=1101, carry=0.
  - A=1111, B=0001, OP=101 -> R=0000, carry=1; then A=0010, B=1011, OP=110 -> R=0111, carry=1; then A=1011, B=0010, OP=110 -> R=1001, carry=0.
  - OP=111 with ALU_TWOS_COMP_EN defined: A=1011 -> R=0101, carry=0; A=0000 -> R=0000, carry=1; same stimulus with the macro undefined -> R=0000, carry=0.
  - Reset asserted mid-stream during a run of ADD operations -> outputs 0000/0 on that edge, and normal results resume on the next edge.

Source files
------------

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: eight opcodes, one-cycle latency, synchronous active-high reset.
// Optional macro ALU_TWOS_COMP_EN enables the two's-complement opcode (otherwise it yields zero).
module alu_4bit (
    input  logic clk,
    input  logic reset,
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic y0,
    input  logic y1,
    input  logic y2,
    input  logic y3,
    input  logic op0,
    input  logic op1,
    input  logic op2,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic carry
);

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpNot  = 3'b001,
        OpOr   = 3'b010,
        OpXor  = 3'b011,
        OpShl  = 3'b100,
        OpAdd  = 3'b101,
        OpSub  = 3'b110,
        OpTwos = 3'b111
    } alu_op_e;

    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [4:0] sum;
    logic [4:0] diff;
    logic [4:0] neg;
    logic [3:0] r_d, r_q;
    logic       carry_d, carry_q;

    assign a  = {x0, x1, x2, x3};
    assign b  = {y0, y1, y2, y3};
    assign op = {op0, op1, op2};

    // Bit 4 of each 5-bit result is the carry (ADD), borrow (SUB) or A==0 flag (negate).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign neg  = {1'b0, ~a} + 5'd1;

    always_comb begin
        r_d     = 4'b0000;
        carry_d = 1'b0;
        case (alu_op_e'(op))
            OpAnd: r_d = a & b;
            OpNot: r_d = ~a;
            OpOr:  r_d = a | b;
            OpXor: r_d = a ^ b;
            OpShl: begin
                r_d     = {a[2:0], 1'b0};
                carry_d = a[3];
            end
            OpAdd: begin
                r_d     = sum[3:0];
                carry_d = sum[4];
            end
            OpSub: begin
                r_d     = diff[3:0];
                carry_d = diff[4];
            end
            OpTwos: begin
`ifdef ALU_TWOS_COMP_EN
                r_d     = neg[3:0];
                carry_d = neg[4];
`else
                r_d     = 4'b0000;
                carry_d = 1'b0;
`endif
            end
            default: begin
                r_d     = 4'b0000;
                carry_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= 4'b0000;
            carry_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            carry_q <= carry_d;
        end
    end

    assign {out0, out1, out2, out3} = r_q;
    assign carry = carry_q;

`ifndef ALU_TWOS_COMP_EN
    logic unused_neg;
    assign unused_neg = ^neg;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Directed self-checking bench for alu_4bit; expected values are hand-computed constants.
module tb_alu_4bit;

    logic clk;
    logic reset;
    logic x0, x1, x2, x3;
    logic y0, y1, y2, y3;
    logic op0, op1, op2;
    logic out0, out1, out2, out3;
    logic carry;

    int checks = 0;
    int errors = 0;

    alu_4bit dut (
        .clk   (clk),
        .reset (reset),
        .x0    (x0),
        .x1    (x1),
        .x2    (x2),
        .x3    (x3),
        .y0    (y0),
        .y1    (y1),
        .y2    (y2),
        .y3    (y3),
        .op0   (op0),
        .op1   (op1),
        .op2   (op2),
        .out0  (out0),
        .out1  (out1),
        .out2  (out2),
        .out3  (out3),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] obs;
    assign obs = {carry, out0, out1, out2, out3};

    // Set inputs, then clock once and settle #1 past the edge.
    task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op);
        reset = rst;
        {x0, x1, x2, x3} = a;
        {y0, y1, y2, y3} = b;
        {op0, op1, op2} = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 4'b1111, 4'b1111, 3'b101);
        checks++;
        if (obs !== 5'b0_0000) begin
            errors++;
            $display("FAIL reset: got c=%b r=%b, want c=0 r=0000", obs[4], obs[3:0]);
        end
    endtask

    task automatic test_logic();
        logic [2:0] ops [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
        logic [3:0] exp [4] = '{4'b0010, 4'b0100, 4'b1011, 4'b1001};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b1011, 4'b0010, ops[i]);
            checks++;
            if (obs !== {1'b0, exp[i]}) begin
                errors++;
                $display("FAIL logic op=%b: got c=%b r=%b, want c=0 r=%b",
                         ops[i], obs[4], obs[3:0], exp[i]);
            end
        end
    endtask

    task automatic test_shift_add();
        step(1'b0, 4'b1011, 4'b0010, 3'b100);
        checks++;
        if (obs !== 5'b1_0110) begin
            errors++;
            $display("FAIL shl: got c=%b r=%b, want c=1 r=0110", obs[4], obs[3:0]);
        end
        step(1'b0, 4'b1011, 4'b0010, 3'b101);
        checks++;
        if (obs !== 5'b0_1101) begin
            errors++;
            $display("FAIL add: got c=%b r=%b, want c=0 r=1101", obs[4], obs[3:0]);
        end
    endtask

    task automatic test_arith();
        logic [3:0] av  [3] = '{4'b1111, 4'b0010, 4'b1011};
        logic [3:0] bv  [3] = '{4'b0001, 4'b1011, 4'b0010};
        logic [2:0] ops [3] = '{3'b101, 3'b110, 3'b110};
        logic [4:0] exp [3] = '{5'b1_0000, 5'b1_0111, 5'b0_1001};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, av[i], bv[i], ops[i]);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL arith #%0d a=%b b=%b op=%b: got c=%b r=%b, want c=%b r=%b",
                         i, av[i], bv[i], ops[i], obs[4], obs[3:0], exp[i][4], exp[i][3:0]);
            end
        end
    endtask

    task automatic test_twos();
        logic [3:0] av  [2] = '{4'b1011, 4'b0000};
`ifdef ALU_TWOS_COMP_EN
        logic [4:0] exp [2] = '{5'b0_0101, 5'b1_0000};
`else
        logic [4:0] exp [2] = '{5'b0_0000, 5'b0_0000};
`endif
        for (int i = 0; i < 2; i++) begin
            // Preload a nonzero result so a stuck output cannot pass.
            step(1'b0, 4'b1111, 4'b1111, 3'b010);
            step(1'b0, av[i], 4'b0110, 3'b111);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL twos a=%b: got c=%b r=%b, want c=%b r=%b",
                         av[i], obs[4], obs[3:0], exp[i][4], exp[i][3:0]);
            end
        end
    endtask

    task automatic test_hold();
        step(1'b0, 4'b0011, 4'b0100, 3'b101);
        {x0, x1, x2, x3} = 4'b1111;
        {op0, op1, op2} = 3'b000;
        #3;
        checks++;
        if (obs !== 5'b0_0111) begin
            errors++;
            $display("FAIL hold: got c=%b r=%b, want c=0 r=0111", obs[4], obs[3:0]);
        end
    endtask

    task automatic test_midstream_reset();
        logic       rv  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] av  [4] = '{4'b0001, 4'b0011, 4'b0101, 4'b0110};
        logic [3:0] bv  [4] = '{4'b0001, 4'b0100, 4'b0101, 4'b0111};
        logic [4:0] exp [4] = '{5'b0_0010, 5'b0_0111, 5'b0_0000, 5'b0_1101};
        for (int i = 0; i < 4; i++) begin
            step(rv[i], av[i], bv[i], 3'b101);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL midreset #%0d: got c=%b r=%b, want c=%b r=%b",
                         i, obs[4], obs[3:0], exp[i][4], exp[i][3:0]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        {x0, x1, x2, x3} = 4'b0000;
        {y0, y1, y2, y3} = 4'b0000;
        {op0, op1, op2} = 3'b000;
        test_reset();
        test_logic();
        test_shift_add();
        test_arith();
        test_twos();
        test_hold();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
